text_buffer: RTL and testbench

TEXT_BUFFER -- requirements
Module: text_buffer

---
 rtl/text_pkg.sv | 29 ++
 rtl/text_buffer_if.sv | 11 +
 rtl/char_fifo.sv | 45 ++++
 rtl/text_buffer.sv | 127 ++++++++++++
 tb/tb_text_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text buffer: control codes, cell fill values and
// a byte classifier that fixes the handling priority of incoming characters.
package text_pkg;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] BS      = 8'h08;
    localparam logic [7:0] FF      = 8'h0C;
    localparam logic [7:0] LEAD_E0 = 8'hE0;
    localparam logic [7:0] LEAD_B8 = 8'hB8;
    localparam logic [7:0] BLANK   = 8'h20;
    localparam logic [7:0] CLEARED = 8'h00;

    typedef enum logic [2:0] {
        K_FF,
        K_CR,
        K_BS,
        K_LEAD,
        K_PRINT
    } char_kind_e;

    function automatic char_kind_e classify(input logic [7:0] ch);
        if (ch == FF)                         return K_FF;
        else if (ch == CR)                    return K_CR;
        else if (ch == BS)                    return K_BS;
        else if (ch == LEAD_E0 || ch == LEAD_B8) return K_LEAD;
        else                                  return K_PRINT;
    endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Character input channel of the text buffer; hold pauses consumption of
// buffered characters without blocking the producer until the FIFO fills.
interface text_buffer_if;
    logic [7:0] ascii;
    logic       in_valid;
    logic       in_ready;
    logic       hold;

    modport master (output ascii, output in_valid, output hold, input in_ready);
    modport slave  (input ascii, input in_valid, input hold, output in_ready);
endinterface

// File: rtl/char_fifo.sv
// Byte FIFO with full/empty flags; a push and a pop may coincide at any fill
// level, and reset discards the contents by clearing pointers and count.
module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en, rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // When full, a push is only taken if the head leaves in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/text_buffer.sv
// Character-cell text buffer: bytes queue in a small FIFO and are applied one
// per cycle to a ROWS x COLS grid with cursor, wrap/scroll and control codes.
module text_buffer
    import text_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 32,
    parameter int SCROLL     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    text_buffer_if.slave               bus,
    output logic [ROWS*COLS*8-1:0]     text_flat,
    output logic [$clog2(ROWS)-1:0]    cursor_row,
    output logic [$clog2(COLS+1)-1:0]  cursor_col,
    output logic                       page_wrap,
    output logic                       overflow
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS+1);
    localparam int CI_W  = $clog2(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS-1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS-1);

    // Ascending ranges put cell (0,0) in the most significant byte.
    typedef logic [0:ROWS-1][0:COLS-1][7:0] grid_t;

    grid_t            grid, grid_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CI_W-1:0]  col_idx, prev_idx;
    logic             wrap_d, next_line;
    logic             full, empty, push;
    logic             vld_p0;
    logic [7:0]       char_p0;

    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign vld_p0       = !empty && !bus.hold;

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (bus.ascii),
        .pop     (vld_p0),
        .rd_data (char_p0),
        .full    (full),
        .empty   (empty)
    );

    assign col_idx  = col_q[CI_W-1:0];
    assign prev_idx = col_idx - CI_W'(1);

    // p0 -> grid: the FIFO head is decoded and applied to grid and cursor
    always_comb begin
        grid_d    = grid;
        row_d     = row_q;
        col_d     = col_q;
        wrap_d    = 1'b0;
        next_line = 1'b0;
        if (vld_p0) begin
            case (classify(char_p0))
                K_FF: begin
                    grid_d = '0;
                    row_d  = '0;
                    col_d  = '0;
                end
                K_CR: begin
                    col_d     = '0;
                    next_line = 1'b1;
                end
                K_BS: begin
                    if (col_q != '0) begin
                        col_d                   = col_q - COL_W'(1);
                        grid_d[row_q][prev_idx] = BLANK;
                    end
                end
                K_LEAD: ;
                default: begin
                    grid_d[row_q][col_idx] = char_p0;
                    if (col_q == LAST_COL) begin
                        col_d     = '0;
                        next_line = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            endcase
            // Line advance acts on grid_d so a character just written to the
            // last row moves up with it when scrolling.
            if (next_line) begin
                if (row_q != LAST_ROW) begin
                    row_d = row_q + ROW_W'(1);
                end else if (SCROLL != 0) begin
                    for (int r = 0; r < ROWS-1; r++) grid_d[r] = grid_d[r+1];
                    grid_d[ROWS-1] = '0;
                end else begin
                    row_d  = '0;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grid      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            page_wrap <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            grid      <= grid_d;
            row_q     <= row_d;
            col_q     <= col_d;
            page_wrap <= wrap_d;
            if (bus.in_valid && full) overflow <= 1'b1;
        end
    end

    assign text_flat  = grid;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: wrap (SCROLL=0) and scroll (SCROLL=1)
// instances share one stimulus stream and are checked against a queue model.
module tb_text_buffer;
    import text_pkg::*;

    localparam int ROWS  = 4;
    localparam int COLS  = 32;
    localparam int DEPTH = 4;
    localparam int W     = ROWS*COLS*8;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] ascii    = 8'h00;
    logic       in_valid = 1'b0;
    logic       hold     = 1'b0;

    always #5 clk = ~clk;

    text_buffer_if if0 ();
    text_buffer_if if1 ();
    assign if0.ascii    = ascii;
    assign if0.in_valid = in_valid;
    assign if0.hold     = hold;
    assign if1.ascii    = ascii;
    assign if1.in_valid = in_valid;
    assign if1.hold     = hold;

    logic [W-1:0] flat0, flat1;
    logic [1:0]   row0, row1;
    logic [5:0]   col0, col1;
    logic         wrap0, wrap1, ovf0, ovf1;

    text_buffer #(.ROWS(ROWS), .COLS(COLS), .SCROLL(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0), .text_flat(flat0),
        .cursor_row(row0), .cursor_col(col0), .page_wrap(wrap0), .overflow(ovf0));
    text_buffer #(.ROWS(ROWS), .COLS(COLS), .SCROLL(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1), .text_flat(flat1),
        .cursor_row(row1), .cursor_col(col1), .page_wrap(wrap1), .overflow(ovf1));

    typedef struct {
        logic [W-1:0] flat;
        int           row;
        int           col;
        bit           wrap;
        bit           ovf;
        bit           rdy;
    } snap_t;

    snap_t      exp_q0[$];
    snap_t      exp_q1[$];
    logic [7:0] pend[$];
    logic [7:0] m_grid [2][ROWS][COLS];
    int         m_row [2];
    int         m_col [2];
    bit         m_wrap [2];
    bit         m_ovf;
    bit         m_acc;
    logic [7:0] m_b;
    int         n_checks = 0;
    int         n_pass   = 0;
    snap_t      s0, s1;

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_grid[k][r][c] = 8'h00;
            m_row[k]  = 0;
            m_col[k]  = 0;
            m_wrap[k] = 1'b0;
        end
        m_ovf = 1'b0;
        pend.delete();
    endtask

    task automatic m_newline(int k);
        if (m_row[k] < ROWS-1) begin
            m_row[k]++;
        end else if (k == 0) begin
            m_row[k]  = 0;
            m_wrap[k] = 1'b1;
        end else begin
            for (int r = 0; r < ROWS-1; r++)
                for (int c = 0; c < COLS; c++) m_grid[k][r][c] = m_grid[k][r+1][c];
            for (int c = 0; c < COLS; c++) m_grid[k][ROWS-1][c] = 8'h00;
        end
    endtask

    task automatic m_apply(int k, logic [7:0] b);
        if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_grid[k][r][c] = 8'h00;
            m_row[k] = 0;
            m_col[k] = 0;
        end else if (b == 8'h0D) begin
            m_col[k] = 0;
            m_newline(k);
        end else if (b == 8'h08) begin
            if (m_col[k] > 0) begin
                m_col[k]--;
                m_grid[k][m_row[k]][m_col[k]] = 8'h20;
            end
        end else if (b != 8'hE0 && b != 8'hB8) begin
            m_grid[k][m_row[k]][m_col[k]] = b;
            m_col[k]++;
            if (m_col[k] == COLS) begin
                m_col[k] = 0;
                m_newline(k);
            end
        end
    endtask

    function automatic snap_t m_snap(int k);
        snap_t s;
        s.flat = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) s.flat[W-1-(r*COLS+c)*8 -: 8] = m_grid[k][r][c];
        s.row  = m_row[k];
        s.col  = m_col[k];
        s.wrap = m_wrap[k];
        s.ovf  = m_ovf;
        s.rdy  = (pend.size() < DEPTH);
        return s;
    endfunction

    // Reference model: FIFO as a queue, one pop per unheld cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reset();
            exp_q0.delete();
            exp_q1.delete();
            exp_q0.push_back(m_snap(0));
            exp_q1.push_back(m_snap(1));
        end else begin
            m_acc     = in_valid && (pend.size() < DEPTH);
            if (in_valid && !m_acc) m_ovf = 1'b1;
            m_wrap[0] = 1'b0;
            m_wrap[1] = 1'b0;
            if (!hold && pend.size() > 0) begin
                m_b = pend.pop_front();
                m_apply(0, m_b);
                m_apply(1, m_b);
            end
            if (m_acc) pend.push_back(ascii);
            exp_q0.push_back(m_snap(0));
            exp_q1.push_back(m_snap(1));
        end
    end

    task automatic chk(int k, string nm, logic [W-1:0] act, logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            s0 = exp_q0.pop_front();
            chk(0, "text_flat",  flat0,                 s0.flat);
            chk(0, "cursor_row", W'(row0),              W'(s0.row));
            chk(0, "cursor_col", W'(col0),              W'(s0.col));
            chk(0, "page_wrap",  W'(wrap0),             W'(s0.wrap));
            chk(0, "overflow",   W'(ovf0),              W'(s0.ovf));
            chk(0, "in_ready",   W'(if0.in_ready),      W'(s0.rdy));
        end
        if (exp_q1.size() > 0) begin
            s1 = exp_q1.pop_front();
            chk(1, "text_flat",  flat1,                 s1.flat);
            chk(1, "cursor_row", W'(row1),              W'(s1.row));
            chk(1, "cursor_col", W'(col1),              W'(s1.col));
            chk(1, "page_wrap",  W'(wrap1),             W'(s1.wrap));
            chk(1, "overflow",   W'(ovf1),              W'(s1.ovf));
            chk(1, "in_ready",   W'(if1.in_ready),      W'(s1.rdy));
        end
    end

    task automatic drive(bit v, logic [7:0] b, bit h);
        in_valid = v;
        ascii    = b;
        hold     = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
    endtask

    function automatic logic [7:0] rand_char();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 6)       return CR;
        else if (sel < 10) return BS;
        else if (sel < 12) return LEAD_E0;
        else if (sel < 14) return LEAD_B8;
        else if (sel < 15) return FF;
        else               return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        send_str("HI");
        idle(4);

        drive(1'b1, FF, 1'b0);
        for (int i = 0; i < COLS; i++) drive(1'b1, 8'h41, 1'b0);
        drive(1'b1, 8'h42, 1'b0);
        idle(4);

        drive(1'b1, FF, 1'b0);
        for (int i = 0; i < ROWS; i++) drive(1'b1, CR, 1'b0);
        idle(4);

        drive(1'b1, FF, 1'b0);
        send_str("A");
        for (int i = 0; i < ROWS-1; i++) drive(1'b1, CR, 1'b0);
        send_str("D");
        drive(1'b1, CR, 1'b0);
        idle(4);

        drive(1'b1, FF, 1'b0);
        send_str("AB");
        drive(1'b1, BS, 1'b0);
        drive(1'b1, LEAD_E0, 1'b0);
        drive(1'b1, LEAD_B8, 1'b0);
        send_str("C");
        idle(3);
        drive(1'b1, FF, 1'b0);
        drive(1'b1, BS, 1'b0);
        idle(3);

        // Consumer held: four bytes fill the FIFO, the fifth is dropped.
        for (int i = 0; i < DEPTH+1; i++) drive(1'b1, 8'h31 + 8'(i), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        idle(6);
        drive(1'b1, FF, 1'b0);
        idle(3);

        // Asynchronous reset in the middle of a burst.
        send_str("XYZ");
        drive(1'b1, 8'h51, 1'b0);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        send_str("Z");
        idle(4);

        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 3) != 0, rand_char(), $urandom_range(0, 9) == 0);
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
